// File: rtl/serial_add_sched_pkg.sv
// Shared types and constants for the bit-serial add scheduler.
// SERIAL_ADD_SCHED_CARRY_OUT_EN widens the result by one bit to carry the final carry-out.
package serial_add_sched_pkg;
  localparam int N_REQ = 2;

`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
  localparam int CO_W = 1;
`else
  localparam int CO_W = 0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/serial_add_scheduler_rr_arbiter_2.sv
// Two-requester round-robin grant, purely combinational.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // on contention the requester not served last wins
      2'b11:   gnt = last[0] ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/serial_add_scheduler.sv
// Arbitrates two requesters and adds their operands one bit per cycle, LSB first.
// Build option: SERIAL_ADD_SCHED_CARRY_OUT_EN appends the final carry as res_sum[WIDTH].
module serial_add_scheduler
  import serial_add_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          in_vld,
  output logic [N_REQ-1:0]          in_rdy,
  input  logic [N_REQ*WIDTH-1:0]    in_a,
  input  logic [N_REQ*WIDTH-1:0]    in_b,
  output logic                      res_vld,
  input  logic                      res_rdy,
  output logic [WIDTH+CO_W-1:0]     res_sum,
  output logic                      res_id,
  output logic                      busy
);
  localparam int CNT_W = $clog2(WIDTH);

  state_e             state, state_nxt;
  logic [1:0]         gnt;
  logic [0:0]         last_q;
  logic               accept, last_bit, sum_bit, carry_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic               carry, id_q;
  logic [CNT_W-1:0]   cnt;
`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
  logic               cout_q;
`endif

  rr_arbiter_2 u_arb (.req(in_vld), .last(last_q), .gnt(gnt));

  always_comb begin
    in_rdy    = (state == IDLE) ? gnt : '0;
    accept    = |(in_vld & in_rdy);
    last_bit  = (cnt == CNT_W'(WIDTH-1));
    sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    busy      = (state != IDLE);
    res_vld   = (state == DONE);
    res_id    = res_vld & id_q;
`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
    res_sum   = res_vld ? {cout_q, sum_sh} : '0;
`else
    res_sum   = res_vld ? sum_sh : '0;
`endif
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (res_rdy)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
      cout_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_sh  <= gnt[1] ? in_a[WIDTH +: WIDTH] : in_a[0 +: WIDTH];
          b_sh  <= gnt[1] ? in_b[WIDTH +: WIDTH] : in_b[0 +: WIDTH];
          id_q  <= gnt[1];
          carry <= 1'b0;
          cnt   <= '0;
        end
        RUN: begin
          // sum bits enter at the MSB so bit 0 lands at sum_sh[0] after WIDTH shifts
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {sum_bit, sum_sh[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          carry  <= last_bit ? 1'b0 : carry_nxt;
`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
          if (last_bit) cout_q <= carry_nxt;
`endif
        end
        DONE: if (res_rdy) last_q <= id_q;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_scheduler.sv
// Scoreboard bench for serial_add_scheduler at WIDTH=8, either carry-out build.
module tb_serial_add_scheduler;
  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SCHED_CARRY_OUT_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif

  typedef struct packed {
    logic          id;
    logic [RW-1:0] sum;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [1:0]           in_vld = '0;
  logic [1:0]           in_rdy;
  logic [2*WIDTH-1:0]   in_a = '0, in_b = '0;
  logic                 res_vld, res_rdy = 1'b1;
  logic [RW-1:0]        res_sum;
  logic                 res_id, busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic order_q[$];

  serial_add_scheduler #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_a(in_a), .in_b(in_b), .res_vld(res_vld), .res_rdy(res_rdy),
    .res_sum(res_sum), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // push expected sums on accept, pop and compare on result transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_vld == 2'b11) begin
        checks++;
        if (in_rdy === 2'b11) begin
          errors++;
          $display("FAIL rdy_onehot: in_rdy=%b required not 11", in_rdy);
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (in_vld[r] && in_rdy[r]) begin
          exp_t e;
          e.id  = r[0];
          e.sum = RW'({1'b0, in_a[r*WIDTH +: WIDTH]} + {1'b0, in_b[r*WIDTH +: WIDTH]});
          sb.push_back(e);
        end
      end
      if (res_vld && res_rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: result sum=%h id=%0d with nothing expected", res_sum, res_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (res_sum !== e.sum || res_id !== e.id) begin
            errors++;
            $display("FAIL sb_result: sum=%h id=%0d required sum=%h id=%0d", res_sum, res_id, e.sum, e.id);
          end
          order_q.push_back(res_id);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_vld = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  // drive one request, then count cycles from the accepting edge to res_vld
  task automatic send(input int r, input logic [7:0] a, input logic [7:0] b, output int lat);
    int n = 0;
    lat = -1;
    @(posedge clk); #1;
    in_vld = '0;
    in_vld[r] = 1'b1;
    in_a[r*WIDTH +: WIDTH] = a;
    in_b[r*WIDTH +: WIDTH] = b;
    @(negedge clk);
    while (!(in_vld[r] && in_rdy[r]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d never accepted, in_rdy=%b", r, in_rdy);
      in_vld = '0;
      return;
    end
    @(posedge clk); #1;
    in_vld = '0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_vld) break;
      checks++;
      if (res_sum !== '0 || res_id !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero: res_sum=%h res_id=%0d required 0 while res_vld low", res_sum, res_id);
      end
    end
    if (!res_vld) begin
      errors++;
      $display("FAIL result_timeout: no res_vld after %0d cycles", lat);
      lat = -1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (res_vld !== 1'b0 || res_sum !== '0 || res_id !== 1'b0 || busy !== 1'b0 || in_rdy !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: vld=%b sum=%h id=%b busy=%b rdy=%b required all zero",
               res_vld, res_sum, res_id, busy, in_rdy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    res_rdy = 1'b1;
    send(0, 8'h5A, 8'h3C, lat);
    checks++;
    if (lat !== 8 || res_sum !== RW'(9'h096) || res_id !== 1'b0) begin
      errors++;
      $display("FAIL basic: lat=%0d sum=%h id=%0d required lat=8 sum=096 id=0", lat, res_sum, res_id);
    end
    @(posedge clk);
  endtask

  task automatic test_carry();
    int lat;
    send(1, 8'hFF, 8'h01, lat);
    checks++;
    if (lat !== 8 || res_sum !== RW'(9'h100) || res_id !== 1'b1) begin
      errors++;
      $display("FAIL carry: lat=%0d sum=%h id=%0d required lat=8 sum=%h id=1", lat, res_sum, res_id, RW'(9'h100));
    end
    @(posedge clk);
  endtask

  task automatic test_round_robin();
    int n = 0;
    do_reset();
    order_q.delete();
    res_rdy = 1'b1;
    @(posedge clk); #1;
    in_a = {8'h33, 8'h11};
    in_b = {8'h44, 8'h22};
    in_vld = 2'b11;
    while (order_q.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_vld = '0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (order_q.size() < 4) begin
      errors++;
      $display("FAIL rr_count: %0d results required at least 4", order_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order_q[i] !== i[0]) begin
          errors++;
          $display("FAIL rr_order: result %0d from requester %0d required %0d", i, order_q[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    res_rdy = 1'b0;
    send(0, 8'h12, 8'h34, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL bp_latency: lat=%0d required 8", lat);
    end
    @(posedge clk); #1;
    in_a = {8'hAA, 8'h55};
    in_b = {8'h01, 8'h02};
    in_vld = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_vld !== 1'b1 || res_sum !== RW'(9'h046) || res_id !== 1'b0 || in_rdy !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d vld=%b sum=%h id=%0d rdy=%b required 1 046 0 00",
                 i, res_vld, res_sum, res_id, in_rdy);
      end
    end
    @(posedge clk); #1;
    in_vld = '0;
    res_rdy = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: busy=%b vld=%b required 0 0", busy, res_vld);
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    int lat;
    res_rdy = 1'b1;
    @(posedge clk); #1;
    in_vld = 2'b01;
    in_a[7:0] = 8'h0F;
    in_b[7:0] = 8'h01;
    @(negedge clk);
    while (!(in_vld[0] && in_rdy[0]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_vld = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (res_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: vld=%b busy=%b required 0 0 during reset", res_vld, busy);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h0F, 8'h01, lat);
    checks++;
    if (lat !== 8 || res_sum !== RW'(9'h010)) begin
      errors++;
      $display("FAIL abort_retry: lat=%0d sum=%h required lat=8 sum=010", lat, res_sum);
    end
    @(posedge clk);
  endtask

  task automatic test_no_carry_leak();
    int lat;
    send(0, 8'h00, 8'h00, lat);
    checks++;
    if (res_sum !== '0) begin
      errors++;
      $display("FAIL leak_zero: sum=%h required 000", res_sum);
    end
    @(posedge clk);
    send(1, 8'h80, 8'h80, lat);
    checks++;
    if (res_sum !== RW'(9'h100)) begin
      errors++;
      $display("FAIL leak_msb: sum=%h required %h", res_sum, RW'(9'h100));
    end
    @(posedge clk);
    send(0, 8'h00, 8'h00, lat);
    checks++;
    if (res_sum !== '0) begin
      errors++;
      $display("FAIL leak_after: sum=%h required 000", res_sum);
    end
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    test_no_carry_leak();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d results outstanding required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_scheduler.md
SERIAL_ADD_SCHEDULER -- requirements
Module: serial_add_scheduler

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be >= 2.
REQ-002 Port clk  input  1: sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1: reset; asynchronous assertion, active-low.
REQ-004 Port in_vld  input  2: per-requester request valid; bit r belongs to requester r.
REQ-005 Port in_rdy  output  2: per-requester accept; request r transfers on in_vld[r] & in_rdy[r].
REQ-006 Port in_a  input  2*WIDTH: operand A; requester r uses bits [r*WIDTH +: WIDTH].
REQ-007 Port in_b  input  2*WIDTH: operand B, same packing as in_a.
REQ-008 Port res_vld  output  1: result valid.
REQ-009 Port res_rdy  input  1: result accept; result transfers on res_vld & res_rdy.
REQ-010 Port res_sum  output  RW: sum, with RW = WIDTH+1 when the carry-out option is compiled in and RW = WIDTH otherwise.
REQ-011 Port res_id  output  1: index of the requester that owns res_sum.
REQ-012 Port busy  output  1: high in every state except IDLE.

Function
REQ-013 The block SHALL be a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, grant SHALL be combinational: the single valid requester wins; if both are valid, the requester not served last wins (round-robin).
REQ-015 in_rdy SHALL be one-hot to the granted requester in IDLE and all-zero in RUN and DONE.
REQ-016 On an accepted request, the block SHALL capture A, B and the requester id, clear the carry and the bit counter, and move to RUN.
REQ-017 RUN SHALL last exactly WIDTH cycles and process bit i (LSB first) in cycle i.
REQ-018 Each RUN cycle SHALL compute sum_i = a_i ^ b_i ^ carry and carry' = a_i&b_i | carry&(a_i^b_i), and shift sum_i into the result register.
REQ-019 On bit WIDTH-1 (the last bit), the block SHALL store the final carry, clear the working carry, and move to DONE.
REQ-020 res_vld SHALL rise on the edge that ends the last RUN cycle, i.e. WIDTH cycles after the accepting edge.
REQ-021 In DONE, res_vld, res_sum and res_id SHALL stay stable until res_rdy is sampled high; the block then returns to IDLE and records res_id as last-served.
REQ-022 A new request SHALL NOT be accepted in the cycle its predecessor's result is accepted; the minimum issue interval is WIDTH+2 cycles.
REQ-023 res_sum and res_id SHALL read zero whenever res_vld is low.
REQ-024 Changes on in_a, in_b or in_vld during RUN or DONE SHALL have no effect.

Reset
REQ-025 While rst_n is low, the block SHALL be in IDLE with res_vld=0, res_sum=0, res_id=0, busy=0, carry=0 and last-served=1, so requester 0 wins the first contention.
REQ-026 A reset that asserts mid-RUN or in DONE SHALL abort the operation immediately and discard its result.

Configuration
REQ-027 When the macro SERIAL_ADD_SCHED_CARRY_OUT_EN is defined, RW SHALL be WIDTH+1 and res_sum[WIDTH] SHALL hold the final carry.
REQ-028 When that macro is undefined, RW SHALL be WIDTH, the final carry SHALL be discarded, and the sum SHALL wrap modulo 2^WIDTH.

Structure
REQ-029 A package serial_add_sched_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the requester-count constant N_REQ = 2.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter_2 with inputs req[1:0] and last[0:0] and output gnt[1:0] (one-hot or zero); it SHALL be purely combinational.

Verification (WIDTH=8)
REQ-031 Requester 0 sends 0x5A+0x3C, res_rdy held high -> res_vld rises exactly 8 cycles after the accept, res_sum=0x096, res_id=0.
REQ-032 Requester 1 sends 0xFF+0x01 -> res_sum=0x100 with the macro defined and 0x00 without it; res_id=1.
REQ-033 Both requesters valid constantly, starting right after reset -> requests are served in the order 0,1,0,1; in_rdy is never 2'b11.
REQ-034 res_rdy held low for 5 cycles in DONE -> res_vld, res_sum and res_id are stable and in_rdy=0 for all 5 cycles; the block returns to IDLE one cycle after res_rdy rises.
REQ-035 rst_n pulsed low during RUN bit 3 of 0x0F+0x01 -> res_vld=0 and busy=0 immediately; a following 0x0F+0x01 yields 0x010.
REQ-036 0x00+0x00, then 0x80+0x80 -> 0x000, then 0x100 with the macro defined or 0x00 without it; no carry leaks between operations.
